// File: rtl/pc_redirect_unit.sv
// Program counter with branch/jump redirect and a post-redirect fetch-flush window.
// Optional accepted-redirect statistics counter is built when PC_BRANCH_STATS_EN is defined.
module pc_redirect_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_PC     = {WIDTH{1'b0}},
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pcsrc,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             flush,
  output logic             redirect,
  output logic [31:0]      taken_count
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};
  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam bit               FLUSH_EN   = (FLUSH_CYCLES != 0);

  state_t           state_r, state_s;
  logic [2:0]       cnt_r, cnt_s;
  logic [WIDTH-1:0] pc_r, pc_s;
  logic             flush_r, redirect_r, accept_s;
  logic [WIDTH-1:0] branch_target_s, jump_target_s;

  assign pc_plus4        = pc_r + PC_STEP;
  assign branch_target_s = pc_plus4 + (branch_offset << 2);
  assign jump_target_s   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

  assign pc       = pc_r;
  assign flush    = flush_r;
  assign redirect = redirect_r;

  // Next-PC selection and RUN/FLUSH sequencing
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pc_s     = pc_r;
    accept_s = 1'b0;
    case (state_r)
      RUN: begin
        if (pcsrc) begin
          pc_s     = branch_target_s;
          accept_s = 1'b1;
        end else if (jump) begin
          pc_s     = jump_target_s;
          accept_s = 1'b1;
        end else if (stall) begin
          pc_s = pc_r;
        end else begin
          pc_s = pc_plus4;
        end
        if (accept_s && FLUSH_EN) begin
          state_s = FLUSH;
          cnt_s   = FLUSH_LOAD;
        end else begin
          state_s = RUN;
          cnt_s   = cnt_r;
        end
      end
      FLUSH: begin
        // Redirect requests here come from squashed instructions.
        if (stall) begin
          pc_s = pc_r;
        end else begin
          pc_s = pc_plus4;
        end
        cnt_s = cnt_r - 3'd1;
        if (cnt_r <= 3'd1) begin
          state_s = RUN;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = RUN;
        cnt_s   = 3'd0;
        pc_s    = pc_r;
      end
    endcase
  end

  // State, PC and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= RUN;
      cnt_r      <= 3'd0;
      pc_r       <= RESET_PC;
      flush_r    <= 1'b0;
      redirect_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pc_r       <= pc_s;
      flush_r    <= (state_s == FLUSH);
      redirect_r <= accept_s;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] taken_r;

  // Saturating accepted-redirect counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_r <= 32'd0;
    end else if (accept_s && (taken_r != 32'hFFFF_FFFF)) begin
      taken_r <= taken_r + 32'd1;
    end
  end

  assign taken_count = taken_r;
`else
  assign taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench: two DUTs (flush window 1 and 3) share randomized inputs
// and are compared every cycle against a remaining-flush-cycles behavioural model.
module tb_pc_redirect_unit;

`ifdef PC_BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcsrc, jump, stall;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;

  logic [31:0] pc_o[2], pc4_o[2], cnt_o[2];
  logic        flush_o[2], redir_o[2];

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;

  int          fc[2] = '{1, 3};
  logic [31:0] m_pc[2];
  int          m_left[2];
  logic        m_redir[2];
  logic [31:0] m_cnt[2];

  always #5 clk = ~clk;

  pc_redirect_unit #(.WIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .reset_n(rst_n), .pcsrc(pcsrc), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .stall(stall),
    .pc(pc_o[0]), .pc_plus4(pc4_o[0]), .flush(flush_o[0]),
    .redirect(redir_o[0]), .taken_count(cnt_o[0]));

  pc_redirect_unit #(.WIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(rst_n), .pcsrc(pcsrc), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .stall(stall),
    .pc(pc_o[1]), .pc_plus4(pc4_o[1]), .flush(flush_o[1]),
    .redirect(redir_o[1]), .taken_count(cnt_o[1]));

  function automatic logic [31:0] jtarget(input logic [31:0] cur, input logic [25:0] idx);
    logic [31:0] nxt;
    nxt = cur + 32'd4;
    return {nxt[31:28], idx, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a redirect in RUN opens a window of fc cycles during which
  // redirect requests are ignored; outside it branch beats jump beats stall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pc[i] <= 32'h0; m_left[i] <= 0; m_redir[i] <= 1'b0; m_cnt[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_left[i] > 0) begin
          m_pc[i]    <= stall ? m_pc[i] : m_pc[i] + 32'd4;
          m_left[i]  <= m_left[i] - 1;
          m_redir[i] <= 1'b0;
        end else if (pcsrc || jump) begin
          m_pc[i]    <= pcsrc ? m_pc[i] + 32'd4 + branch_offset * 32'd4
                              : jtarget(m_pc[i], jump_index);
          m_left[i]  <= fc[i];
          m_redir[i] <= 1'b1;
          if (STATS && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] <= m_cnt[i] + 32'd1;
        end else begin
          m_pc[i]    <= stall ? m_pc[i] : m_pc[i] + 32'd4;
          m_redir[i] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pc[%0d]", i),       pc_o[i],              m_pc[i]);
        chk($sformatf("pc_plus4[%0d]", i), pc4_o[i],             m_pc[i] + 32'd4);
        chk($sformatf("flush[%0d]", i),    {31'd0, flush_o[i]},  {31'd0, (m_left[i] > 0)});
        chk($sformatf("redirect[%0d]", i), {31'd0, redir_o[i]},  {31'd0, m_redir[i]});
        chk($sformatf("taken[%0d]", i),    cnt_o[i],             m_cnt[i]);
      end
    end
  end

  task automatic cyc(input logic p, input logic [31:0] off, input logic j,
                     input logic [25:0] idx, input logic s);
    pcsrc = p; branch_offset = off; jump = j; jump_index = idx; stall = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; pcsrc = 1'b0; jump = 1'b0; stall = 1'b0;
    branch_offset = 32'h0; jump_index = 26'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_pc", pc_o[0], 32'h0);
    chk("rst_flush", {31'd0, flush_o[0]}, 32'd0);
    chk("rst_redirect", {31'd0, redir_o[0]}, 32'd0);
    chk("rst_taken", cnt_o[0], 32'd0);
    rst_n = 1'b1;

    // Sequential fetch
    idle(); chk("seq4", pc_o[0], 32'h4);
    idle(); chk("seq8", pc_o[0], 32'h8);
    idle(); chk("seq12", pc_o[0], 32'hC);

    // Position at 0x40, then the taken branch
    cyc(1'b1, 32'd11, 1'b0, 26'h0, 1'b0); chk("to_3c", pc_o[0], 32'h3C);
    idle(); chk("at_40", pc_o[0], 32'h40);
    cyc(1'b1, 32'd3, 1'b0, 26'h0, 1'b0);
    chk("br_pc", pc_o[0], 32'h50);
    chk("br_redirect", {31'd0, redir_o[0]}, 32'd1);
    chk("br_flush", {31'd0, flush_o[0]}, 32'd1);
    idle();
    chk("br_after", pc_o[0], 32'h54);
    chk("br_flush_end", {31'd0, flush_o[0]}, 32'd0);
    chk("br_redir_end", {31'd0, redir_o[0]}, 32'd0);

    // Backward branch with wrap
    cyc(1'b1, 32'hFFFF_FFE9, 1'b0, 26'h0, 1'b0); chk("to_fffc", pc_o[0], 32'hFFFF_FFFC);
    idle(); chk("wrap0", pc_o[0], 32'h0);
    cyc(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0); chk("back_br", pc_o[0], 32'hFFFF_FFFC);
    idle(); chk("wrap_again", pc_o[0], 32'h0);

    // Conflicts
    cyc(1'b1, 32'h3E, 1'b0, 26'h0, 1'b0);
    idle(); chk("at_100", pc_o[0], 32'h100);
    cyc(1'b1, 32'd1, 1'b1, 26'h3FF_FFFF, 1'b0); chk("br_wins", pc_o[0], 32'h108);
    cyc(1'b1, 32'd100, 1'b0, 26'h0, 1'b0); chk("flush_ignores", pc_o[0], 32'h10C);
    chk("flush_no_redir", {31'd0, redir_o[0]}, 32'd0);
    cyc(1'b1, 32'd1, 1'b0, 26'h0, 1'b1); chk("br_over_stall", pc_o[0], 32'h114);
    chk("br_over_stall_r", {31'd0, redir_o[0]}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 26'h0, 1'b1); chk("flush_stall", pc_o[0], 32'h114);
    idle(); chk("at_118", pc_o[0], 32'h118);

    // Jump and stall
    cyc(1'b1, 32'h03FF_FFB8, 1'b0, 26'h0, 1'b0); chk("to_0ffffffc", pc_o[0], 32'h0FFF_FFFC);
    idle(); chk("at_1000", pc_o[0], 32'h1000_0000);
    cyc(1'b0, 32'h0, 1'b1, 26'h10, 1'b0); chk("jump", pc_o[0], 32'h1000_0040);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 26'h0, 1'b1); chk("stall_hold", pc_o[0], 32'h1000_0040);
    end
    idle(); chk("stall_rel", pc_o[0], 32'h1000_0044);
    chk("taken9", cnt_o[0], STATS ? 32'd9 : 32'd0);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 5) == 0), $urandom(), ($urandom_range(0, 5) == 0),
          26'($urandom()), ($urandom_range(0, 3) == 0));
    end

    // Reset during the second flush cycle of the 3-cycle unit
    repeat (4) idle();
    cyc(1'b0, 32'h0, 1'b1, 26'h5, 1'b0);
    idle();
    chk("mid_flush_active", {31'd0, flush_o[1]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc_o[1], 32'h0);
    chk("async_flush", {31'd0, flush_o[1]}, 32'd0);
    chk("async_pc0", pc_o[0], 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk("post_rst_flush", {31'd0, flush_o[1]}, 32'd0);
    chk("post_rst_pc", pc_o[1], 32'h4);

    // Five accepted redirects for the statistics counter
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 32'(k), 1'b0, 26'h0, 1'b0);
      repeat (4) idle();
    end
    chk("taken5_a", cnt_o[0], STATS ? 32'd5 : 32'd0);
    chk("taken5_b", cnt_o[1], STATS ? 32'd5 : 32'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter owner for the MIPS datapath, and the consumer of the PCSrc branch decision from the branch AND gate.
- Holds the PC register and computes PC+4, the branch target and the jump target.
- Selects the next PC from pcsrc, jump and stall.
- Sequences a fetch-flush window after every taken redirect so that wrong-path instructions are squashed.

Parameters:
- WIDTH, 32, PC/address width; must be at least 29.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- FLUSH_CYCLES, 1, number of cycles flush is held after an accepted redirect; 0 to 7; 0 disables the flush window.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- pcsrc  input  1  taken-branch decision (branch & zero).
- branch_offset  input  WIDTH  sign-extended immediate, in words.
- jump  input  1  unconditional jump request.
- jump_index  input  26  J-type instruction index.
- stall  input  1  hold PC (hazard unit).
- pc  output  WIDTH  current fetch address.
- pc_plus4  output  WIDTH  pc + 4, combinational.
- flush  output  1  squash the IF/ID instruction.
- redirect  output  1  one-cycle pulse: a redirect was accepted on the last edge.
- taken_count  output  32  accepted-redirect counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, reset_n low):
  - pc = RESET_PC, flush = 0, redirect = 0, taken_count = 0.
  - State = RUN, flush counter = 0.
  - Deasserting reset mid-flush leaves the block in RUN with no flush pending.
- Arithmetic (all modulo 2^WIDTH; wrap-around is silent):
  - pc_plus4 = pc + 4.
  - branch_target = pc_plus4 + (branch_offset << 2).
  - jump_target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00}.
  - pc[1:0] is always 00.
- States: RUN and FLUSH.
- RUN, next-PC priority per edge (highest first):
  1. pcsrc = 1 -> pc <= branch_target. This is an accepted redirect.
  2. jump = 1 -> pc <= jump_target. This is an accepted redirect.
  3. stall = 1 -> pc holds.
  4. Otherwise -> pc <= pc_plus4.
- pcsrc and jump both high: the branch wins; the jump is dropped and not counted.
- Redirect overrides stall: the branch resolves downstream of the stalled stage.
- On an accepted redirect:
  - redirect = 1 for exactly the following cycle.
  - If FLUSH_CYCLES > 0: go to FLUSH, load the counter with FLUSH_CYCLES, flush = 1 from the next cycle.
  - If FLUSH_CYCLES = 0: stay in RUN; flush never asserts.
- FLUSH:
  - flush = 1 in every cycle spent in FLUSH.
  - pcsrc and jump are ignored; they come from squashed instructions and are not counted.
  - stall = 1 holds pc; otherwise pc <= pc_plus4.
  - The counter decrements every cycle regardless of stall.
  - Counter reaching 1 -> return to RUN on that edge, so flush lasts exactly FLUSH_CYCLES cycles.
- All outputs except pc_plus4 are registered. Redirect latency is 1 cycle: target visible on pc the cycle after pcsrc is sampled.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - taken_count increments by 1 on each accepted redirect, branch or jump.
  - It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined:
  - taken_count is tied to 0 and no counter logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset and sequential fetch: release reset with no inputs -> pc reads 0, 4, 8, 12 on successive edges; flush = 0; redirect = 0.
- Taken branch:
  - Stimulus: pc = 0x40, pcsrc = 1, branch_offset = 3.
  - Response: next pc = 0x50; redirect = 1 for one cycle; flush = 1 for exactly FLUSH_CYCLES = 1 cycle; then pc = 0x54.
- Backward branch with wrap:
  - Stimulus: pc = 0x0, pcsrc = 1, branch_offset = 32'hFFFF_FFFE (-2).
  - Response: pc = 0xFFFF_FFFC.
  - Follow-up: pc = 0xFFFF_FFFC, no redirect -> next pc = 0x0.
- Conflicts:
  - pcsrc = 1 and jump = 1 together at pc = 0x100, offset = 1 -> pc = 0x108 (branch wins).
  - pcsrc = 1 with stall = 1 -> redirect still taken.
  - pcsrc = 1 during FLUSH -> ignored; pc = target + 4.
- Jump and stall:
  - Stimulus: pc = 0x1000_0000, jump = 1, jump_index = 26'h10.
  - Response: pc = 0x1000_0040.
  - Then stall = 1 for 3 cycles -> pc holds 0x1000_0040.
  - Then stall = 0 -> pc = 0x1000_0044.
- Reset mid-flush and stats:
  - FLUSH_CYCLES = 3; assert reset_n = 0 during the 2nd flush cycle -> pc = RESET_PC and flush = 0 immediately, with no clock edge needed.
  - With PC_BRANCH_STATS_EN defined, 5 accepted redirects -> taken_count = 5; with the macro undefined -> taken_count = 0.
